// File: rtl/ccsds_ldpc_pkg.sv
// Shared constants and types for the CCSDS (8160,7136) LDPC output path.
package ccsds_ldpc_pkg;

  localparam int          CW_BITS    = 8160;
  localparam int          CADU_BYTES = 1024;
  localparam logic [31:0] ASM_WORD   = 32'h1ACFFC1D;

  // Randomizer state loaded at reset and at the start of every frame.
  localparam logic [7:0]  LFSR_SEED  = 8'hFF;

  // Packer FSM. FLUSH holds a zero-padded partial byte after an early tlast
  // until the output register can take it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ASM   = 2'd1,
    ST_DATA  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/ccsds_randomizer_lfsr.sv
// CCSDS pseudo-randomizer, h(x) = x^8 + x^7 + x^5 + x^3 + 1, Fibonacci form.
// lfsr[7] holds the oldest sequence bit and is the current output; new bits
// enter at lfsr[0]. From the all-ones seed the sequence reads FF 48 0E C0 ...
module ccsds_randomizer_lfsr
  import ccsds_ldpc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic advance,
  output logic seq
);

  logic [7:0] lfsr;

  // Reseed on init, otherwise step once per consumed sequence bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (init) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      // a[n+8] = a[n+7] ^ a[n+5] ^ a[n+3] ^ a[n]
      lfsr <= {lfsr[6:0], lfsr[0] ^ lfsr[2] ^ lfsr[4] ^ lfsr[7]};
    end
  end

  assign seq = lfsr[7];

endmodule

// File: rtl/ccsds_ldpc_asm_packer.sv
// Turns the encoder's 1-bit codeword stream into byte-wide CADUs:
// 4 ASM bytes followed by the codeword packed MSB-first, optionally
// randomized. A single output register feeds the 8-bit AXI-Stream port.
module ccsds_ldpc_asm_packer #(
  parameter logic [31:0] ASM_WORD = ccsds_ldpc_pkg::ASM_WORD,
  parameter int          CW_BITS  = ccsds_ldpc_pkg::CW_BITS,
  parameter bit          RAND_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_err
);

  import ccsds_ldpc_pkg::*;

  localparam int              CW_BYTES  = CW_BITS / 8;
  localparam int              BW        = (CW_BYTES > 1) ? $clog2(CW_BYTES) : 1;
  localparam logic [BW-1:0]   LAST_BYTE = BW'(CW_BYTES - 1);

  state_e        state;
  logic [1:0]    asm_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    pack_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          last_q;
  logic          err_q;

  logic          loadable;
  logic          accept;
  logic          frame_start;
  logic          seq;
  logic          bit_in;
  logic          last_bit;
  logic [7:0]    pack_next;
  logic [7:0]    asm_byte;

  // The output register can take a byte when empty or draining this cycle.
  assign loadable    = !valid_q || m_axis_tready;
  // Input stalls only when the 8th bit would need a full output register.
  assign s_axis_tready = (state == ST_DATA) && ((bit_cnt != 3'd7) || loadable);
  assign accept      = s_axis_tvalid && s_axis_tready;
  assign frame_start = (state == ST_IDLE) && s_axis_tvalid;
  assign bit_in      = s_axis_tdata ^ (RAND_EN & seq);
  assign last_bit    = (byte_cnt == LAST_BYTE) && (bit_cnt == 3'd7);
  // Place the incoming bit at its MSB-first position; unfilled bits stay 0,
  // which gives the zero padding for a short final byte for free.
  assign pack_next   = pack_q | ({8{bit_in}} & (8'h80 >> bit_cnt));

  ccsds_randomizer_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (frame_start),
    .advance (accept),
    .seq     (seq)
  );

  // Select the ASM byte for the current position, first-sent byte first.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely
    // combinational even if a branch is ever left out.
    asm_byte = ASM_WORD[31:24];
    unique case (asm_cnt)
      2'd0: asm_byte = ASM_WORD[31:24];
      2'd1: asm_byte = ASM_WORD[23:16];
      2'd2: asm_byte = ASM_WORD[15:8];
      2'd3: asm_byte = ASM_WORD[7:0];
    endcase
  end

  // Frame FSM together with the packer, counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      asm_cnt  <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      pack_q   <= 8'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // A consumed byte empties the register unless a new one loads below.
      if (valid_q && m_axis_tready) valid_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            state   <= ST_ASM;
            asm_cnt <= 2'd0;
          end
        end

        ST_ASM: begin
          if (loadable) begin
            data_q  <= asm_byte;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            asm_cnt <= asm_cnt + 2'd1;
            if (asm_cnt == 2'd3) begin
              state    <= ST_DATA;
              bit_cnt  <= 3'd0;
              byte_cnt <= '0;
              pack_q   <= 8'd0;
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            bit_cnt <= bit_cnt + 3'd1;
            pack_q  <= pack_next;
            // tlast must coincide exactly with the final codeword bit.
            if (last_bit != s_axis_tlast) err_q <= 1'b1;
            if (bit_cnt == 3'd7) begin
              data_q   <= pack_next;
              valid_q  <= 1'b1;
              last_q   <= last_bit || s_axis_tlast;
              pack_q   <= 8'd0;
              byte_cnt <= byte_cnt + BW'(1);
              if (last_bit || s_axis_tlast) state <= ST_IDLE;
            end else if (s_axis_tlast) begin
              state <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (loadable) begin
            data_q  <= pack_q;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign frame_err     = err_q;

endmodule

// File: doc/ccsds_ldpc_asm_packer.md
Name: ccsds_ldpc_asm_packer

Overview:
Downstream stage of the CCSDS (8160,7136) LDPC encoder. It consumes the encoder's 1-bit AXI-Stream codeword output. For each codeword it emits the 32-bit attached sync marker (ASM), then the codeword packed MSB-first into bytes, optionally XORed with the CCSDS pseudo-randomizer. The result is a 1024-byte channel access data unit (CADU): 4 ASM bytes plus 1020 codeword bytes, delivered on an 8-bit AXI-Stream output towards the modulator/framer.

Parameters:
ASM_WORD, 32'h1ACFFC1D, attached sync marker, sent MSB first
CW_BITS, 8160, codeword length in bits; must be a multiple of 8
RAND_EN, 1, 1 = XOR codeword bits with the CCSDS randomizer; 0 = bypass

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  1  codeword bit, first-transmitted bit first
s_axis_tvalid  in  1  input bit valid
s_axis_tready  out  1  packer accepts a bit this cycle
s_axis_tlast  in  1  marks the last bit of a codeword
m_axis_tdata  out  8  output byte; bit 7 is the first-transmitted bit
m_axis_tvalid  out  1  output byte valid
m_axis_tready  in  1  downstream accepts the byte
m_axis_tlast  out  1  marks the last byte of a CADU (byte 1023)
frame_err  out  1  one-cycle pulse on a codeword length violation

Behaviour:
- Reset: asynchronous assertion clears all state. Values after reset:
  - m_axis_tdata = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
  - s_axis_tready = 0, frame_err = 0.
  - FSM = IDLE, all counters = 0, randomizer LFSR = 8'hFF.
- Reset mid-frame abandons the partial CADU; no output is produced for it.
- Output register: a single byte register carrying m_axis_tdata/tvalid/tlast.
  - It may be loaded when it is empty, or when it is being consumed in the same cycle (m_axis_tvalid && m_axis_tready).
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata and tlast must hold stable.
- FSM states:
  - IDLE: s_axis_tready = 0. When s_axis_tvalid = 1, go to ASM, clear asm_cnt, seed the LFSR to 8'hFF.
  - ASM: load ASM bytes 0x1A, 0xCF, 0xFC, 0x1D in order, one per loadable cycle. After the 4th load, go to DATA. s_axis_tready = 0 throughout.
  - DATA:
    - Bits shift into an 8-bit packer, MSB first. bit_cnt counts 0..7; byte_cnt counts 0..(CW_BITS/8 - 1).
    - s_axis_tready = 1 when bit_cnt != 7, or when the output register is loadable.
    - On accepting the 8th bit, the packed byte loads the output register. The same-cycle incoming bit is included (no extra bubble).
    - m_axis_tlast = 1 on the byte with byte_cnt = CW_BITS/8 - 1.
- Randomizer (RAND_EN = 1):
  - Polynomial h(x) = x^8 + x^7 + x^5 + x^3 + 1, Fibonacci form. Output bit = LFSR[7]; feedback = LFSR[7]^LFSR[5]^LFSR[3]^LFSR[0]... (implement so the first sequence bytes are FF 48 0E C0 9A 0D 70 BC).
  - The LFSR advances once per accepted data bit. It is never applied to ASM bytes.
  - The LFSR is reseeded to 8'hFF at every frame start.
- Length checking:
  - Early tlast (s_axis_tlast on accepted bit index < CW_BITS - 1):
    - Zero-pad the partial byte and emit it with m_axis_tlast = 1.
    - Pulse frame_err for one cycle.
    - Return to IDLE (the CADU is short).
  - Missing tlast (bit CW_BITS - 1 accepted with tlast = 0):
    - Close the frame normally (m_axis_tlast on the last byte).
    - Pulse frame_err for one cycle.
    - Return to IDLE. The next bit starts a new frame.
- After the last byte loads, go to IDLE. A new frame may begin the next cycle, giving a minimum 1-cycle gap before the ASM.
- Throughput: 1 bit/clk on input with m_axis_tready held at 1. Latency from the 8th bit accepted to m_axis_tvalid is 1 cycle.

Decomposition:
- Shared package ccsds_ldpc_pkg holds:
  - constants CW_BITS = 8160, CADU_BYTES = 1024, ASM_WORD = 32'h1ACFFC1D;
  - the randomizer seed 8'hFF;
  - the FSM state encoding.
- One natural sub-module: ccsds_randomizer_lfsr. It has ports clk, rst_n, init, advance, and a 1-bit sequence output.

Test Plan:
- RAND_EN = 0, all-zero 8160-bit codeword, m_axis_tready = 1 → 1A CF FC 1D, then 1020 × 00; tlast only on byte 1023; frame_err = 0.
- RAND_EN = 1, all-zero codeword → after the ASM, bytes FF 48 0E C0 9A 0D 70 BC …; sequence period 255 bytes; the ASM is unrandomized.
- Two back-to-back encoder codewords (encoder response vectors), compared byte-exact against reference CADUs; the second frame's LFSR restarts at FF.
- Random m_axis_tready (50%) → no byte lost or duplicated; tdata/tlast stable while stalled; s_axis_tready drops only on the byte boundary.
- tlast on bit 12 → 1A CF FC 1D, then two bytes with the second zero-padded and tlast = 1; frame_err pulses once.
- rst_n asserted at byte 500, then a full frame → outputs clear immediately; the next CADU is complete and correct.
